// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Owner encoding matches the core-wide OWN_* values used by mem_arb.vh.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  function automatic int streak_width(input int max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_rsp_hold.sv
// Read-response holder: passes fresh memory data through on rvalid and
// keeps presenting the last delivered word while the consumer is stalled.
module mem_rsp_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (rvalid) begin
      hold <= din;
    end
  end

  assign dout = rvalid ? din : hold;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between fetch and load/store, data first,
// with a bounded data streak so fetch cannot starve.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              stall_if,
  output logic              stall_d
);

  localparam int STREAK_W = streak_width(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak;
  owner_t              owner, owner_nxt;
  logic                kill_flag;
  logic                force_if;

  // Fetch only wins a contended cycle once data has had its full streak.
  assign force_if = if_req & (streak == STREAK_MAX);
  assign d_gnt    = d_req & ~force_if;
  assign if_gnt   = if_req & ~d_gnt;
  assign stall_if = if_req & ~if_gnt;
  assign stall_d  = d_req & ~d_gnt;

  assign mem_en   = if_gnt | d_gnt;
  assign mem_we   = d_gnt ? d_we : 4'b0000;
  assign mem_addr = d_gnt ? d_addr : if_addr;
  assign mem_din  = d_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!if_req || if_gnt) begin
      streak <= '0;
    end else if (d_gnt && (streak != STREAK_MAX)) begin
      streak <= streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      kill_flag <= 1'b0;
    end else begin
      owner     <= owner_nxt;
      kill_flag <= if_gnt & if_kill;
    end
  end

  // Writes complete at grant, so only reads claim the next response cycle.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (if_gnt) begin
      owner_nxt = OWN_IF;
    end else if (d_gnt && (d_we == 4'b0000)) begin
      owner_nxt = OWN_D;
    end
  end

  assign if_rvalid = (owner == OWN_IF) & ~kill_flag & ~if_kill;
  assign d_rvalid  = (owner == OWN_D);

  mem_rsp_hold #(.DATA_W(DATA_W)) u_if_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .rvalid (if_rvalid),
    .din    (mem_dout),
    .dout   (if_rdata)
  );

  mem_rsp_hold #(.DATA_W(DATA_W)) u_d_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .rvalid (d_rvalid),
    .din    (mem_dout),
    .dout   (d_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: arbitration table, directed corner sequences and
// randomized traffic against a cycle-level reference model with its own memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int MAXS   = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_kill, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_gnt, d_rvalid;
  logic [3:0]        d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              stall_if, stall_d;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .stall_if(stall_if), .stall_d(stall_d)
  );

  function automatic logic [31:0] init_val(input int i);
    logic [31:0] v;
    v = (i < 4) ? 32'(32'h1000 + i) : (32'hC0DE0000 | 32'(i[15:0]));
    return v;
  endfunction

  // Synchronous-read byte-writable memory; preloaded on the first edge.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we == 4'b0000) mem_dout <= mem[mem_addr];
      else for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  int                m_streak;
  bit                m_pend_if, m_pend_kill, m_pend_d;
  logic [DATA_W-1:0] m_pend_if_data, m_pend_d_data, m_hold_if, m_hold_d;

  logic              s_if_gnt, s_d_gnt, s_if_rvalid, s_d_rvalid, s_stall_if, s_stall_d;
  logic [DATA_W-1:0] s_if_rdata, s_d_rdata;

  task automatic model_clear();
    m_streak = 0; m_pend_if = 0; m_pend_kill = 0; m_pend_d = 0;
    m_pend_if_data = '0; m_pend_d_data = '0; m_hold_if = '0; m_hold_d = '0;
  endtask

  task automatic cycle(input logic ir, input logic [ADDR_W-1:0] ia, input logic ik,
                       input logic dr, input logic [3:0] dwe, input logic [ADDR_W-1:0] da,
                       input logic [DATA_W-1:0] dwd);
    logic e_dg, e_ig, e_irv, e_drv;
    logic [DATA_W-1:0] e_ird, e_drd;
    @(negedge clk);
    if_req = ir; if_addr = ia; if_kill = ik;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    e_dg  = dr && !(ir && (m_streak == MAXS));
    e_ig  = ir && !e_dg;
    e_irv = m_pend_if && !m_pend_kill && !ik;
    e_drv = m_pend_d;
    e_ird = e_irv ? m_pend_if_data : m_hold_if;
    e_drd = e_drv ? m_pend_d_data : m_hold_d;
    s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_rvalid = if_rvalid; s_d_rvalid = d_rvalid;
    s_stall_if = stall_if; s_stall_d = stall_d; s_if_rdata = if_rdata; s_d_rdata = d_rdata;
    check("if_gnt", if_gnt, e_ig);
    check("d_gnt", d_gnt, e_dg);
    check("stall_if", stall_if, ir && !e_ig);
    check("stall_d", stall_d, dr && !e_dg);
    check("if_rvalid", if_rvalid, e_irv);
    check("d_rvalid", d_rvalid, e_drv);
    check("if_rdata", if_rdata, e_ird);
    check("d_rdata", d_rdata, e_drd);
    check("mem_en", mem_en, e_ig || e_dg);
    check("mem_we", mem_we, e_dg ? dwe : 4'b0000);
    if (e_ig || e_dg) check("mem_addr", mem_addr, e_dg ? da : ia);
    if (e_dg && dwe != 4'b0000) check("mem_din", mem_din, dwd);
    @(posedge clk);
    if (e_irv) m_hold_if = m_pend_if_data;
    if (e_drv) m_hold_d = m_pend_d_data;
    m_pend_if      = e_ig;
    m_pend_kill    = e_ig && ik;
    m_pend_if_data = ref_mem[ia];
    m_pend_d       = e_dg && (dwe == 4'b0000);
    m_pend_d_data  = ref_mem[da];
    if (e_dg && dwe != 4'b0000)
      for (int b = 0; b < 4; b++) if (dwe[b]) ref_mem[da][8*b +: 8] = dwd[8*b +: 8];
    if (!ir || e_ig) m_streak = 0;
    else if (e_dg && m_streak < MAXS) m_streak++;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 4'b0000, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    if_req = 0; if_addr = '0; if_kill = 0; d_req = 0; d_we = '0; d_addr = '0; d_wdata = '0;
    rst_n = 1'b0;
    #1;
    check("rst_if_rvalid", if_rvalid, 1'b0);
    check("rst_d_rvalid", d_rvalid, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  typedef struct packed {
    logic ir;
    logic dr;
    logic eig;
    logic edg;
  } vec_t;

  vec_t tbl [16];

  logic              r_ir, r_dr, r_ik;
  logic [ADDR_W-1:0] r_ia, r_da;
  logic [3:0]        r_dwe;
  logic [DATA_W-1:0] r_dwd;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    model_clear();
    rst_n = 1'b0;
    do_reset();

    // Fetch-only stream, back to back
    for (int i = 0; i < 5; i++) begin
      cycle(i < 4, ADDR_W'(i), 1'b0, 1'b0, 4'b0000, '0, '0);
      if (i < 4) check("a_if_gnt", s_if_gnt, 1'b1);
      if (i > 0) begin
        check("a_if_rvalid", s_if_rvalid, 1'b1);
        check("a_if_rdata", s_if_rdata, 32'(32'h1000 + i - 1));
      end
      check("a_d_rvalid", s_d_rvalid, 1'b0);
    end

    // Contention pattern: four data grants then one forced fetch
    for (int k = 0; k < 16; k++) begin
      cycle(tbl[k].ir, 14'd7, 1'b0, tbl[k].dr, 4'b0000, 14'd6, '0);
      check("tbl_if_gnt", s_if_gnt, tbl[k].eig);
      check("tbl_d_gnt", s_d_gnt, tbl[k].edg);
      check("tbl_stall_if", s_stall_if, tbl[k].ir & ~tbl[k].eig);
      check("tbl_stall_d", s_stall_d, tbl[k].dr & ~tbl[k].edg);
    end
    idle();

    // Partial store then load of the merged word
    cycle(1'b0, '0, 1'b0, 1'b1, 4'b0011, 14'd5, 32'hAAAA5555);
    check("st_d_gnt", s_d_gnt, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, 4'b0000, 14'd5, '0);
    check("st_no_rvalid", s_d_rvalid, 1'b0);
    idle();
    check("ld_rvalid", s_d_rvalid, 1'b1);
    check("ld_merged", s_d_rdata, 32'hC0DE5555);

    // Kill in grant cycle, kill in response cycle, kill in both
    cycle(1'b1, 14'd1, 1'b1, 1'b0, 4'b0000, '0, '0);
    check("k0_if_gnt", s_if_gnt, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, 4'b0000, 14'd2, '0);
    check("k1_if_rvalid", s_if_rvalid, 1'b0);
    cycle(1'b1, 14'd3, 1'b0, 1'b0, 4'b0000, '0, '0);
    check("k2_d_rvalid", s_d_rvalid, 1'b1);
    check("k2_d_rdata", s_d_rdata, 32'h00001002);
    cycle(1'b0, '0, 1'b1, 1'b1, 4'b0000, 14'd0, '0);
    check("k3_if_rvalid", s_if_rvalid, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 4'b0000, '0, '0);
    check("k4_d_rvalid", s_d_rvalid, 1'b1);
    check("k4_d_rdata", s_d_rdata, 32'h00001000);
    cycle(1'b1, 14'd0, 1'b1, 1'b0, 4'b0000, '0, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, 4'b0000, '0, '0);
    check("k6_if_rvalid", s_if_rvalid, 1'b0);
    cycle(1'b1, 14'd2, 1'b0, 1'b0, 4'b0000, '0, '0);
    idle();
    check("k8_if_rvalid", s_if_rvalid, 1'b1);
    check("k8_if_rdata", s_if_rdata, 32'h00001002);

    // Response hold across idle cycles
    cycle(1'b0, '0, 1'b0, 1'b1, 4'b1111, 14'd9, 32'hDEADBEEF);
    cycle(1'b0, '0, 1'b0, 1'b1, 4'b0000, 14'd9, '0);
    idle();
    check("h_rdata", s_d_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("h_hold", s_d_rdata, 32'hDEADBEEF);
    end
    cycle(1'b0, '0, 1'b0, 1'b1, 4'b0000, 14'd5, '0);
    idle();
    check("h_update", s_d_rdata, 32'hC0DE5555);

    // Reset during an outstanding load response
    cycle(1'b0, '0, 1'b0, 1'b1, 4'b0000, 14'd9, '0);
    do_reset();
    idle();
    check("r_d_rvalid", s_d_rvalid, 1'b0);
    check("r_d_rdata", s_d_rdata, 32'h0);
    cycle(1'b1, 14'd3, 1'b0, 1'b0, 4'b0000, '0, '0);
    check("r_if_gnt", s_if_gnt, 1'b1);
    idle();
    check("r_if_rvalid", s_if_rvalid, 1'b1);
    check("r_if_rdata", s_if_rdata, 32'h00001003);

    // Randomized traffic, requesters obey hold-until-grant
    r_ir = 0; r_dr = 0; r_ia = '0; r_da = '0; r_dwe = '0; r_dwd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!r_ir || s_if_gnt) begin
        r_ir = ($urandom % 4) != 0;
        r_ia = ADDR_W'($urandom % 16);
      end
      if (!r_dr || s_d_gnt) begin
        r_dr  = ($urandom % 3) != 0;
        r_da  = ADDR_W'($urandom % 16);
        r_dwe = (($urandom % 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
        r_dwd = $urandom;
      end
      r_ik = ($urandom % 5) == 0;
      cycle(r_ir, r_ia, r_ik, r_dr, r_dwe, r_da, r_dwd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, synchronous-read memory between the instruction-fetch requester and the load/store requester of the 3-stage RISC-V core. Data accesses win by default, and a streak counter bounds fetch starvation. The block routes each one-cycle-latency read response back to its owner and holds it stable for stalled consumers. It discards fetch responses killed by a branch mispredict or jump redirect, and drives the per-requester stall signals the pipeline control uses to freeze stages.

## Interface
- ADDR_W, 14, word address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive contended data grants before fetch is forced through (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held with stable if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_kill  in  1  redirect; cancels in-flight fetch responses (see Operation)
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_gnt
- d_we  in  4  byte write enables; 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data accepted (combinational); for writes this is completion
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we==0
- stall_if  out  1  if_req & ~if_gnt
- stall_d  out  1  d_req & ~d_gnt

## Operation
- Arbitration happens every cycle and grants at most one requester.
  - d_req alone → data granted. if_req alone → fetch granted.
  - Both asserted → data granted, unless streak == MAX_D_STREAK; then fetch is granted.
- Streak counter, width clog2(MAX_D_STREAK+1):
  - increments on a data grant while if_req=1;
  - clears on a fetch grant or whenever if_req=0;
  - saturates at MAX_D_STREAK.
- Memory port mux:
  - mem_en = if_gnt | d_gnt.
  - On fetch grant: mem_addr=if_addr, mem_we=0.
  - On data grant: mem_addr=d_addr, mem_we=d_we, mem_din=d_wdata.
  - When no grant: mem_addr and mem_din are don't-care; mem_we=0.
- Owner register `owner ∈ {OWN_NONE, OWN_IF, OWN_D}` forms the state machine. At every edge it loads:
  - OWN_IF on a fetch grant;
  - OWN_D on a data read grant;
  - OWN_NONE otherwise, including data writes.
- Kill flag: set at the edge when fetch is granted in a cycle with if_kill=1; cleared otherwise.
- Response cycle, owner=OWN_IF: if_rvalid = ~kill_flag & ~if_kill.
- Response cycle, owner=OWN_D: d_rvalid = 1. if_kill never affects data.
- rdata hold: while rvalid, x_rdata = mem_dout and the value is captured into a hold register. Otherwise x_rdata = hold register, stable until that requester's next response.
- A new grant may issue in the same cycle as a response (full throughput, back-to-back).

## Timing
- Grant to rvalid latency is exactly 1 cycle; writes have no response cycle.
- gnt and stall are combinational from req/streak. rvalid is combinational from owner/kill_flag/if_kill only.
- Reset values: owner=OWN_NONE, streak=0, kill_flag=0, both hold registers=0. Therefore if_rvalid=d_rvalid=0 and rdata=0.
- Reset asserted mid-read: the outstanding response is dropped, and no rvalid appears after release.
- if_kill asserted in both grant cycle and response cycle: a single suppression, no side effects.
- A requester dropping req before gnt is illegal; the block does not check it.

## Structure
- Shared header mem_arb.vh: OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2. Included alongside opcode.vh.
- Sub-module mem_rsp_hold (DATA_W; inputs clk, rst_n, rvalid, din; output dout), instantiated once per requester.
- Arbiter, streak counter, owner FSM and kill flag live in mem_port_arbiter.

## Test plan
- Fetch-only reads to addr 0..3 with memory preloaded 0x1000+i → if_gnt every cycle; if_rvalid one cycle later each, data 0x1000..0x1003; d_rvalid stays 0.
- d_req read and if_req together, MAX_D_STREAK=4, d_req held for 10 cycles → pattern of 4 data grants, 1 fetch grant, repeated; stall_if high exactly on the denied cycles.
- Store d_we=4'b0011 to addr 5, then load addr 5 → d_gnt on the store with no d_rvalid; load returns the merged word with only the low halfword updated.
- Fetch granted at cycle t with if_kill at t; separately, a fetch granted at t with if_kill at t+1 → if_rvalid=0 in both cases; a data load in flight at the same time still gives d_rvalid=1.
- Load returns 0xDEADBEEF, then 5 idle cycles → d_rdata holds 0xDEADBEEF throughout; the following load updates it.
- rst_n pulled low the cycle after a load grant → no d_rvalid, owner=OWN_NONE and d_rdata=0 after release; the first post-reset fetch behaves normally.
